ef_i2c_target: RTL and testbench

I2C target (slave) core for the EF I2C peripheral family: the responder side of the bus driven by the existing I2C master controller. It synchronises and filters SCL/SDA and detects START/STOP. It matches a programmable 7-bit address, ACKs it, and then streams write bytes out or read bytes in over a simple byte handshake. When no read byte is ready, it stretches SCL. It sits between the pads (open-drain, oen-style) and a future bus-wrapper register block.

---
 rtl/ef_i2c_target.sv | 254 +++++++++++++++++++++++++
 tb/tb_ef_i2c_target.sv | 286 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/ef_i2c_target.sv
// I2C target: 2-flop sync + FILTER_LEN glitch filter on SCL/SDA, 7-bit address match, byte rx/tx handshake.
// Outputs registered 3+FILTER_LEN clocks after a pad edge; with no tx byte ready it stretches SCL until tx_valid_i.
module ef_i2c_target #(
  parameter int FILTER_LEN = 3
) (
  input  logic       clk_i,
  input  logic       rst_i,
  input  logic       en_i,
  input  logic [6:0] own_addr_i,
  input  logic       scl_i,
  output logic       scl_o,
  output logic       scl_oen_o,
  input  logic       sda_i,
  output logic       sda_o,
  output logic       sda_oen_o,
  output logic [7:0] rx_data_o,
  output logic       rx_valid_o,
  input  logic [7:0] tx_data_i,
  input  logic       tx_valid_i,
  output logic       tx_ready_o,
  output logic       addr_match_o,
  output logic       rw_o,
  output logic       start_o,
  output logic       stop_o,
  output logic       busy_o
);

  typedef enum logic [3:0] {
    S_IDLE, S_ADDR, S_ADDR_ACK, S_RX_BYTE, S_RX_ACK,
    S_TX_LOAD, S_TX_BYTE, S_TX_ACK, S_IGNORE
  } state_t;

  localparam logic [2:0] FILT_MAX = 3'(FILTER_LEN - 1);

  // Index 0 is SCL, index 1 is SDA.
  logic [1:0] pad, sync1, sync2, filt, filt_q;
  logic [2:0] fcnt [2];

  assign pad = {sda_i, scl_i};

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      sync1  <= 2'b11;
      sync2  <= 2'b11;
      filt   <= 2'b11;
      filt_q <= 2'b11;
      for (int i = 0; i < 2; i++) fcnt[i] <= '0;
    end else begin
      sync1  <= pad;
      sync2  <= sync1;
      filt_q <= filt;
      for (int i = 0; i < 2; i++) begin
        if (sync2[i] == filt[i]) begin
          fcnt[i] <= '0;
        end else if (fcnt[i] == FILT_MAX) begin
          filt[i] <= sync2[i];
          fcnt[i] <= '0;
        end else begin
          fcnt[i] <= fcnt[i] + 3'd1;
        end
      end
    end
  end

  logic scl_rise, scl_fall, sda_rise, sda_fall, scl_high, start_det, stop_det;
  assign scl_rise  = filt[0] & ~filt_q[0];
  assign scl_fall  = ~filt[0] & filt_q[0];
  assign sda_rise  = filt[1] & ~filt_q[1];
  assign sda_fall  = ~filt[1] & filt_q[1];
  // SCL must be high both before and after the SDA edge, so an SDA change that lands
  // together with the release of a stretch is not taken as START/STOP.
  assign scl_high  = filt[0] & filt_q[0];
  assign start_det = sda_fall & scl_high;
  assign stop_det  = sda_rise & scl_high;

  state_t     state_q, state_d;
  logic [3:0] cnt_q, cnt_d;
  logic [7:0] sh_q, sh_d, rx_data_q, rx_data_d;
  logic       rw_q, rw_d, busy_q, busy_d;
  logic       scl_oen_q, scl_oen_d, sda_oen_q, sda_oen_d;
  logic       rx_valid_q, rx_valid_d, tx_ready_q, tx_ready_d;
  logic       addr_match_q, addr_match_d, start_q, start_d, stop_q, stop_d;

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q      <= S_IDLE;
      cnt_q        <= '0;
      sh_q         <= '0;
      rx_data_q    <= '0;
      rw_q         <= 1'b0;
      busy_q       <= 1'b0;
      scl_oen_q    <= 1'b1;
      sda_oen_q    <= 1'b1;
      rx_valid_q   <= 1'b0;
      tx_ready_q   <= 1'b0;
      addr_match_q <= 1'b0;
      start_q      <= 1'b0;
      stop_q       <= 1'b0;
    end else begin
      state_q      <= state_d;
      cnt_q        <= cnt_d;
      sh_q         <= sh_d;
      rx_data_q    <= rx_data_d;
      rw_q         <= rw_d;
      busy_q       <= busy_d;
      scl_oen_q    <= scl_oen_d;
      sda_oen_q    <= sda_oen_d;
      rx_valid_q   <= rx_valid_d;
      tx_ready_q   <= tx_ready_d;
      addr_match_q <= addr_match_d;
      start_q      <= start_d;
      stop_q       <= stop_d;
    end
  end

  always_comb begin
    state_d      = state_q;
    cnt_d        = cnt_q;
    sh_d         = sh_q;
    rx_data_d    = rx_data_q;
    rw_d         = rw_q;
    busy_d       = busy_q;
    scl_oen_d    = scl_oen_q;
    sda_oen_d    = sda_oen_q;
    rx_valid_d   = 1'b0;
    tx_ready_d   = 1'b0;
    addr_match_d = 1'b0;
    start_d      = 1'b0;
    stop_d       = 1'b0;

    if (!en_i) begin
      state_d   = S_IDLE;
      cnt_d     = '0;
      busy_d    = 1'b0;
      scl_oen_d = 1'b1;
      sda_oen_d = 1'b1;
    end else if (start_det) begin
      state_d   = S_ADDR;
      cnt_d     = '0;
      busy_d    = 1'b1;
      start_d   = 1'b1;
      scl_oen_d = 1'b1;
      sda_oen_d = 1'b1;
    end else if (stop_det) begin
      state_d   = S_IDLE;
      cnt_d     = '0;
      busy_d    = 1'b0;
      stop_d    = 1'b1;
      scl_oen_d = 1'b1;
      sda_oen_d = 1'b1;
    end else begin
      case (state_q)
        S_ADDR: begin
          if (scl_rise && cnt_q != 4'd8) begin
            sh_d  = {sh_q[6:0], filt[1]};
            cnt_d = cnt_q + 4'd1;
          end else if (scl_fall && cnt_q == 4'd8) begin
            cnt_d = '0;
            if (sh_q[7:1] == own_addr_i) begin
              rw_d         = sh_q[0];
              addr_match_d = 1'b1;
              sda_oen_d    = 1'b0;
              state_d      = S_ADDR_ACK;
            end else begin
              state_d = S_IGNORE;
            end
          end
        end
        S_ADDR_ACK: begin
          if (scl_fall) begin
            sda_oen_d = 1'b1;
            cnt_d     = '0;
            if (rw_q) begin
              scl_oen_d = 1'b0;
              state_d   = S_TX_LOAD;
            end else begin
              state_d = S_RX_BYTE;
            end
          end
        end
        S_RX_BYTE: begin
          if (scl_rise && cnt_q != 4'd8) begin
            sh_d  = {sh_q[6:0], filt[1]};
            cnt_d = cnt_q + 4'd1;
          end else if (scl_fall && cnt_q == 4'd8) begin
            rx_data_d  = sh_q;
            rx_valid_d = 1'b1;
            sda_oen_d  = 1'b0;
            cnt_d      = '0;
            state_d    = S_RX_ACK;
          end
        end
        S_RX_ACK: begin
          if (scl_fall) begin
            sda_oen_d = 1'b1;
            state_d   = S_RX_BYTE;
          end
        end
        S_TX_LOAD: begin
          if (tx_valid_i) begin
            tx_ready_d = 1'b1;
            sh_d       = tx_data_i;
            sda_oen_d  = tx_data_i[7];
            scl_oen_d  = 1'b1;
            cnt_d      = '0;
            state_d    = S_TX_BYTE;
          end else begin
            scl_oen_d = 1'b0;
          end
        end
        S_TX_BYTE: begin
          if (scl_rise && cnt_q != 4'd8) begin
            cnt_d = cnt_q + 4'd1;
          end else if (scl_fall) begin
            if (cnt_q == 4'd8) begin
              sda_oen_d = 1'b1;
              cnt_d     = '0;
              state_d   = S_TX_ACK;
            end else begin
              sh_d      = {sh_q[6:0], 1'b0};
              sda_oen_d = sh_q[6];
            end
          end
        end
        S_TX_ACK: begin
          if (scl_rise && filt[1]) begin
            state_d = S_IGNORE;
          end else if (scl_fall) begin
            scl_oen_d = 1'b0;
            state_d   = S_TX_LOAD;
          end
        end
        default: begin
          scl_oen_d = 1'b1;
          sda_oen_d = 1'b1;
        end
      endcase
    end
  end

  assign scl_o        = 1'b0;
  assign sda_o        = 1'b0;
  assign scl_oen_o    = scl_oen_q;
  assign sda_oen_o    = sda_oen_q;
  assign rx_data_o    = rx_data_q;
  assign rx_valid_o   = rx_valid_q;
  assign tx_ready_o   = tx_ready_q;
  assign addr_match_o = addr_match_q;
  assign rw_o         = rw_q;
  assign start_o      = start_q;
  assign stop_o       = stop_q;
  assign busy_o       = busy_q;

endmodule

// File: tb/tb_ef_i2c_target.sv
// Bench for ef_i2c_target: bit-banged I2C master on a wired-AND bus, scoreboard of expected
// pulse events checked by a separate monitor, plus direct checks of bus-level ACK/data.
module tb_ef_i2c_target;

  localparam int FL = 3;
  localparam int Q  = 8;

  localparam logic [2:0] EV_START = 3'd0;
  localparam logic [2:0] EV_STOP  = 3'd1;
  localparam logic [2:0] EV_ADDR  = 3'd2;
  localparam logic [2:0] EV_RX    = 3'd3;
  localparam logic [2:0] EV_TX    = 3'd4;

  typedef struct packed {
    logic [2:0] kind;
    logic [7:0] dat;
  } ev_t;

  logic       clk = 1'b0;
  logic       rst_i, en_i;
  logic [6:0] own_addr;
  logic       m_scl, m_sda;
  logic       scl_line, sda_line;
  logic       scl_o, scl_oen_o, sda_o, sda_oen_o;
  logic [7:0] rx_data_o, tx_data;
  logic       rx_valid_o, tx_valid, tx_ready_o, addr_match_o, rw_o;
  logic       start_o, stop_o, busy_o;

  int  n_tests = 0;
  int  n_fail  = 0;
  ev_t exp_q[$];
  int  run_len = 0;
  int  last_run = 0;

  always #5 clk = ~clk;

  assign scl_line = m_scl & scl_oen_o;
  assign sda_line = m_sda & sda_oen_o;

  ef_i2c_target #(.FILTER_LEN(FL)) dut (
    .clk_i(clk), .rst_i(rst_i), .en_i(en_i), .own_addr_i(own_addr),
    .scl_i(scl_line), .scl_o(scl_o), .scl_oen_o(scl_oen_o),
    .sda_i(sda_line), .sda_o(sda_o), .sda_oen_o(sda_oen_o),
    .rx_data_o(rx_data_o), .rx_valid_o(rx_valid_o),
    .tx_data_i(tx_data), .tx_valid_i(tx_valid), .tx_ready_o(tx_ready_o),
    .addr_match_o(addr_match_o), .rw_o(rw_o),
    .start_o(start_o), .stop_o(stop_o), .busy_o(busy_o)
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    n_tests++;
    if (act !== req) begin
      n_fail++;
      $display("FAIL %s actual=%0h required=%0h", name, act, req);
    end
  endtask

  task automatic push(input logic [2:0] k, input logic [7:0] d);
    ev_t e;
    e.kind = k;
    e.dat  = d;
    exp_q.push_back(e);
  endtask

  task automatic mon_ev(input logic [2:0] k, input logic [7:0] d);
    ev_t e;
    n_tests++;
    if (exp_q.size() == 0) begin
      n_fail++;
      $display("FAIL unexpected_event actual=kind%0d/%02h required=none", k, d);
    end else begin
      e = exp_q.pop_front();
      if (e.kind != k || e.dat != d) begin
        n_fail++;
        $display("FAIL event actual=kind%0d/%02h required=kind%0d/%02h", k, d, e.kind, e.dat);
      end
    end
  endtask

  // Monitor: every output pulse must match the next expected event.
  always @(negedge clk) begin
    if (!rst_i) begin
      if (start_o)      mon_ev(EV_START, 8'h00);
      if (stop_o)       mon_ev(EV_STOP, 8'h00);
      if (addr_match_o) mon_ev(EV_ADDR, {7'd0, rw_o});
      if (rx_valid_o)   mon_ev(EV_RX, rx_data_o);
      if (tx_ready_o)   mon_ev(EV_TX, 8'h00);
    end
  end

  // Length of the most recent SCL stretch, in clocks.
  always @(negedge clk) begin
    if (!scl_oen_o) begin
      run_len++;
    end else begin
      if (run_len != 0) last_run = run_len;
      run_len = 0;
    end
  end

  task automatic wait_clk(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic wait_scl_high();
    int k;
    k = 0;
    while (!scl_line && k < 4000) begin
      @(negedge clk);
      k++;
    end
    if (k >= 4000) begin
      n_tests++;
      n_fail++;
      $display("FAIL scl_release actual=0 required=1");
    end
  endtask

  task automatic m_start();
    m_sda = 1'b1; wait_clk(Q);
    m_scl = 1'b1; wait_scl_high(); wait_clk(Q);
    m_sda = 1'b0; wait_clk(Q);
    m_scl = 1'b0; wait_clk(Q);
  endtask

  task automatic m_stop();
    m_sda = 1'b0; wait_clk(Q);
    m_scl = 1'b1; wait_scl_high(); wait_clk(Q);
    m_sda = 1'b1; wait_clk(Q);
  endtask

  task automatic m_bit(input logic b, output logic r);
    m_sda = b; wait_clk(Q);
    m_scl = 1'b1; wait_scl_high(); wait_clk(Q);
    r = sda_line; wait_clk(Q);
    m_scl = 1'b0; wait_clk(Q);
  endtask

  task automatic m_write_byte(input logic [7:0] d, output logic ack);
    logic r;
    for (int i = 7; i >= 0; i--) m_bit(d[i], r);
    m_bit(1'b1, ack);
  endtask

  task automatic m_read_byte(output logic [7:0] d);
    logic r;
    d = '0;
    for (int i = 0; i < 8; i++) begin
      m_bit(1'b1, r);
      d = {d[6:0], r};
    end
  endtask

  initial begin
    #900000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic       ack, r;
    logic [7:0] d;

    rst_i = 1'b1; en_i = 1'b1; own_addr = 7'h42;
    m_scl = 1'b1; m_sda = 1'b1; tx_valid = 1'b0; tx_data = 8'h00;
    wait_clk(5);
    check("rst_scl_oen", scl_oen_o, 1);
    check("rst_sda_oen", sda_oen_o, 1);
    check("rst_pad_vals", {scl_o, sda_o}, 0);
    check("rst_rx_data", rx_data_o, 0);
    check("rst_rw", rw_o, 0);
    check("rst_busy", busy_o, 0);
    check("rst_pulses", {rx_valid_o, tx_ready_o, addr_match_o, start_o, stop_o}, 0);
    rst_i = 1'b0;
    wait_clk(20);

    // Write: 0x84, 0xA5, 0x3C
    push(EV_START, 8'h00); m_start();
    check("wr_busy", busy_o, 1);
    push(EV_ADDR, 8'h00);  m_write_byte(8'h84, ack); check("wr_addr_ack", ack, 0);
    check("wr_rw", rw_o, 0);
    push(EV_RX, 8'hA5);    m_write_byte(8'hA5, ack); check("wr_b0_ack", ack, 0);
    push(EV_RX, 8'h3C);    m_write_byte(8'h3C, ack); check("wr_b1_ack", ack, 0);
    push(EV_STOP, 8'h00);  m_stop();
    wait_clk(10);
    check("wr_busy_after", busy_o, 0);
    check("wr_rx_data", rx_data_o, 8'h3C);

    // Address mismatch
    push(EV_START, 8'h00); m_start();
    m_write_byte(8'h86, ack); check("mm_addr_nack", ack, 1);
    m_write_byte(8'hFF, ack); check("mm_data_nack", ack, 1);
    push(EV_STOP, 8'h00);  m_stop();
    wait_clk(10);
    check("mm_busy_after", busy_o, 0);

    // Read with a 200-clock stretch, then a second byte the master NACKs
    fork
      begin : provider
        int k;
        k = 0;
        while (scl_oen_o && k < 5000) begin @(negedge clk); k++; end
        check("rd_stretch_seen", (k < 5000), 1);
        repeat (200) @(negedge clk);
        tx_data = 8'h5A; tx_valid = 1'b1;
        k = 0;
        do begin @(negedge clk); k++; end while (!tx_ready_o && k < 5000);
        tx_data = 8'hC3;
        k = 0;
        do begin @(negedge clk); k++; end while (!tx_ready_o && k < 5000);
        tx_valid = 1'b0;
      end
      begin : master
        push(EV_START, 8'h00); m_start();
        push(EV_ADDR, 8'h01);  push(EV_TX, 8'h00);
        m_write_byte(8'h85, ack); check("rd_addr_ack", ack, 0);
        m_read_byte(d);
        check("rd_b0_data", d, 8'h5A);
        check("rd_stretch_len", last_run, 201);
        push(EV_TX, 8'h00);
        m_bit(1'b0, r);
        m_read_byte(d);
        check("rd_b1_data", d, 8'hC3);
        m_bit(1'b1, r);
        wait_clk(10);
        check("rd_nack_sda_rel", sda_oen_o, 1);
        check("rd_nack_scl_rel", scl_oen_o, 1);
        check("rd_rw", rw_o, 1);
        push(EV_STOP, 8'h00); m_stop();
      end
    join
    wait_clk(10);

    // Repeated START: write 0x11, then switch to a read
    tx_data = 8'h77; tx_valid = 1'b1;
    push(EV_START, 8'h00); m_start();
    push(EV_ADDR, 8'h00);  m_write_byte(8'h84, ack); check("rs_wr_ack", ack, 0);
    push(EV_RX, 8'h11);    m_write_byte(8'h11, ack); check("rs_b0_ack", ack, 0);
    push(EV_START, 8'h00); m_start();
    push(EV_ADDR, 8'h01);  push(EV_TX, 8'h00);
    m_write_byte(8'h85, ack); check("rs_rd_ack", ack, 0);
    m_read_byte(d);
    check("rs_rd_data", d, 8'h77);
    tx_valid = 1'b0;
    m_bit(1'b1, r);
    push(EV_STOP, 8'h00); m_stop();
    wait_clk(10);

    // Glitch on SDA shorter than the filter while SCL is high
    m_sda = 1'b0; wait_clk(FL - 1);
    m_sda = 1'b1; wait_clk(30);
    check("glitch_busy", busy_o, 0);

    // Reset while the target is ACKing its address
    push(EV_START, 8'h00); m_start();
    push(EV_ADDR, 8'h00);
    for (int i = 7; i >= 0; i--) m_bit(logic'((8'h84 >> i) & 1), r);
    check("rst_mid_ack_driven", sda_oen_o, 0);
    rst_i = 1'b1;
    @(posedge clk); #1;
    check("rst_mid_sda_rel", sda_oen_o, 1);
    @(negedge clk); rst_i = 1'b0;
    check("rst_mid_busy", busy_o, 0);
    m_bit(1'b1, r); check("rst_mid_no_ack", r, 1);
    m_write_byte(8'hA5, ack); check("rst_mid_no_rx_ack", ack, 1);
    push(EV_START, 8'h00); m_start();
    push(EV_ADDR, 8'h00);  m_write_byte(8'h84, ack); check("rst_mid_fresh_ack", ack, 0);
    push(EV_STOP, 8'h00);  m_stop();
    wait_clk(10);

    // Disabled target ignores the bus entirely
    en_i = 1'b0;
    m_start();
    m_write_byte(8'h84, ack); check("dis_no_ack", ack, 1);
    m_stop();
    wait_clk(10);
    check("dis_busy", busy_o, 0);
    en_i = 1'b1;

    wait_clk(50);
    check("queue_drained", exp_q.size(), 0);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
